// File: rtl/tohost_sig_dump_ctrl.sv
// Snoops AHB-Lite writes to the tohost word. On the pass code it streams the
// signature region out of RAM over a valid/ready port, one word per RD/CAP/OUT pass.
module tohost_sig_dump_ctrl #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter logic [31:0] DUMP_BGN    = 32'h0000_2000,
  parameter logic [31:0] DUMP_END    = 32'h0000_2100,
  parameter int          RAM_AW      = 22
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              ENABLE,
  input  logic              M_HSEL,
  input  logic [1:0]        M_HTRANS,
  input  logic              M_HWRITE,
  input  logic [2:0]        M_HSIZE,
  input  logic [31:0]       M_HADDR,
  input  logic [31:0]       M_HWDATA,
  input  logic              M_HREADY,
  input  logic              M_HREADYOUT,
  output logic              RAM_RE,
  output logic [RAM_AW-1:0] RAM_ADDR,
  input  logic [31:0]       RAM_RDATA,
  output logic              SIG_VALID,
  output logic [31:0]       SIG_DATA,
  output logic              SIG_LAST,
  input  logic              SIG_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [31:0]       TOHOST_CODE,
  output logic [15:0]       WORD_CNT
);

  localparam logic [31:0] BGN_AL     = {DUMP_BGN[31:2], 2'b00};
  localparam logic        HAS_REGION = (DUMP_END > BGN_AL);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_OUT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        match_q;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        last_q, last_d;
  logic [31:0] code_q, code_d;
  logic        pass_q, pass_d;
  logic [15:0] cnt_q, cnt_d;
  logic        detect;
  logic        unused_bits;

  assign unused_bits = ^{M_HTRANS[0], addr_q[1:0], addr_q[31:RAM_AW+2]};

  // Address phase is registered; data-phase wait states leave match_q untouched.
  always_ff @(posedge CLK) begin
    if (RES) begin
      match_q <= 1'b0;
    end else if (M_HREADY && M_HREADYOUT) begin
      match_q <= M_HSEL && M_HTRANS[1] && M_HWRITE && (M_HSIZE == 3'b010) &&
                 (M_HADDR == TOHOST_ADDR);
    end
  end

  assign detect = match_q && M_HREADY && M_HREADYOUT;

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      code_q  <= '0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      code_q  <= code_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    code_d  = code_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ENABLE && detect) begin
          code_d = M_HWDATA;
          pass_d = (M_HWDATA == 32'd1);
          cnt_d  = '0;
          if ((M_HWDATA == 32'd1) && HAS_REGION) begin
            addr_d  = BGN_AL;
            state_d = S_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        data_d  = RAM_RDATA;
        last_d  = ((addr_q + 32'd4) >= DUMP_END);
        state_d = S_OUT;
      end
      S_OUT: begin
        if (SIG_READY) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 32'd4;
            state_d = S_RD;
          end
        end
      end
      S_DONE: begin
        if (!ENABLE) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
          code_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Disarming mid-dump abandons the stream, even over a pending handshake.
    if (!ENABLE && (state_q == S_RD || state_q == S_CAP || state_q == S_OUT)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign RAM_RE      = (state_q == S_RD);
  assign RAM_ADDR    = addr_q[RAM_AW+1:2];
  assign SIG_VALID   = (state_q == S_OUT);
  assign SIG_DATA    = data_q;
  assign SIG_LAST    = last_q;
  assign BUSY        = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_OUT);
  assign DONE        = (state_q == S_DONE);
  assign PASS        = pass_q;
  assign TOHOST_CODE = code_q;
  assign WORD_CNT    = cnt_q;

endmodule

// File: tb/tb_tohost_sig_dump_ctrl.sv
// Bench for tohost_sig_dump_ctrl: AHB snoop stimulus, RAM model and a
// stream scoreboard built from the region's word list.
module tb_tohost_sig_dump_ctrl;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam logic [31:0] BGN    = 32'h0000_2000;
  localparam logic [31:0] ENDA   = 32'h0000_2100;
  localparam int          NW     = (ENDA - BGN) / 4;
  localparam int          BASE_W = BGN / 4;

  logic        CLK = 0, RES, ENABLE;
  logic        M_HSEL, M_HWRITE, M_HREADY, M_HREADYOUT;
  logic [1:0]  M_HTRANS;
  logic [2:0]  M_HSIZE;
  logic [31:0] M_HADDR, M_HWDATA;
  logic        RAM_RE;
  logic [21:0] RAM_ADDR;
  logic [31:0] RAM_RDATA;
  logic        SIG_VALID, SIG_LAST, SIG_READY, BUSY, DONE, PASS;
  logic [31:0] SIG_DATA, TOHOST_CODE;
  logic [15:0] WORD_CNT;

  tohost_sig_dump_ctrl dut (
    .CLK(CLK), .RES(RES), .ENABLE(ENABLE),
    .M_HSEL(M_HSEL), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HADDR(M_HADDR), .M_HWDATA(M_HWDATA), .M_HREADY(M_HREADY), .M_HREADYOUT(M_HREADYOUT),
    .RAM_RE(RAM_RE), .RAM_ADDR(RAM_ADDR), .RAM_RDATA(RAM_RDATA),
    .SIG_VALID(SIG_VALID), .SIG_DATA(SIG_DATA), .SIG_LAST(SIG_LAST), .SIG_READY(SIG_READY),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .TOHOST_CODE(TOHOST_CODE), .WORD_CNT(WORD_CNT)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] exp_mem [NW];
  int          mon_idx, re_cnt, vld_cyc, cyc, last_re, stall, rdy_mode;
  logic        have_re, per_chk;
  logic [31:0] last_word;
  logic        p_vld, p_rdy, p_last, p_en;
  logic [31:0] p_data;
  int unsigned ram_k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RAM: data valid exactly one cycle after the strobe, garbage otherwise.
  initial forever begin
    @(posedge CLK);
    if (RAM_RE) begin
      ram_k = 32'(RAM_ADDR) - BASE_W;
      RAM_RDATA <= (ram_k < NW) ? exp_mem[ram_k] : 32'hDEAD_BEEF;
    end else begin
      RAM_RDATA <= $urandom;
    end
  end

  // Sink ready generator.
  initial forever begin
    @(posedge CLK); #1;
    case (rdy_mode)
      0: SIG_READY = 1'b1;
      1: SIG_READY = ($urandom_range(0, 3) != 0);
      default: begin
        if (SIG_VALID && mon_idx == 2 && stall < 10) begin
          SIG_READY = 1'b0;
          stall++;
        end else begin
          SIG_READY = 1'b1;
        end
      end
    endcase
  end

  // Stream scoreboard: word i of the region must carry exp_mem[i], LAST only on NW-1.
  initial forever begin
    @(negedge CLK);
    cyc++;
    if (RAM_RE) begin
      re_cnt++;
      chk("ram_addr", 32'(RAM_ADDR), 32'(BASE_W + mon_idx));
      if (per_chk && have_re) chk("re_period", 32'(cyc - last_re), 32'd3);
      have_re = 1'b1;
      last_re = cyc;
    end
    if (SIG_VALID) vld_cyc++;
    if (p_vld && !p_rdy && p_en) begin
      chk("hold_vld", 32'(SIG_VALID), 32'd1);
      chk("hold_data", SIG_DATA, p_data);
      chk("hold_last", 32'(SIG_LAST), 32'(p_last));
    end
    if (SIG_VALID && SIG_READY) begin
      if (mon_idx >= NW) begin
        chk("overrun", 32'(mon_idx), 32'(NW - 1));
      end else begin
        chk("sig_data", SIG_DATA, exp_mem[mon_idx]);
        chk("sig_last", 32'(SIG_LAST), 32'(mon_idx == NW - 1));
      end
      if (SIG_LAST) last_word = SIG_DATA;
      mon_idx++;
    end
    p_vld = SIG_VALID; p_rdy = SIG_READY; p_data = SIG_DATA; p_last = SIG_LAST;
    p_en = ENABLE && !RES;
  end

  task automatic clear_mon(input logic per);
    @(posedge CLK); #1;
    mon_idx = 0; re_cnt = 0; vld_cyc = 0; have_re = 1'b0; per_chk = per; last_word = '0;
  endtask

  task automatic fill_mem(input logic ramp);
    for (int i = 0; i < NW; i++) exp_mem[i] = ramp ? 32'(i) * 32'h0101_0101 : $urandom;
  endtask

  task automatic ahb_xfer(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                          input logic wr, input int waits);
    @(posedge CLK); #1;
    M_HSEL = 1'b1; M_HTRANS = 2'b10; M_HWRITE = wr; M_HSIZE = sz; M_HADDR = a;
    M_HREADY = 1'b1; M_HREADYOUT = 1'b1;
    @(posedge CLK); #1;
    M_HSEL = 1'b0; M_HTRANS = 2'b00; M_HWDATA = d;
    for (int i = 0; i < waits; i++) begin
      M_HREADY = 1'b0; M_HREADYOUT = 1'b0;
      @(negedge CLK);
      chk("ws_quiet", 32'({BUSY, DONE}), 32'd0);
      @(posedge CLK); #1;
    end
    M_HREADY = 1'b1; M_HREADYOUT = 1'b1;
    @(negedge CLK);
    chk("detect_cycle_busy", 32'(BUSY), 32'd0);
    @(posedge CLK); #1;
    M_HWDATA = $urandom;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!DONE && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(tag, 32'(DONE), 32'd1);
  endtask

  task automatic disarm();
    @(posedge CLK); #1; ENABLE = 1'b0;
    @(posedge CLK); #1; ENABLE = 1'b1;
  endtask

  initial begin
    RES = 1'b1; ENABLE = 1'b0; rdy_mode = 0; stall = 0; cyc = 0;
    M_HSEL = 0; M_HTRANS = 0; M_HWRITE = 0; M_HSIZE = 0; M_HADDR = 0; M_HWDATA = 0;
    M_HREADY = 1; M_HREADYOUT = 1; SIG_READY = 1; RAM_RDATA = 0;
    mon_idx = 0; re_cnt = 0; vld_cyc = 0; have_re = 0; per_chk = 0; last_word = 0;
    p_vld = 0; p_rdy = 0; p_last = 0; p_en = 0; p_data = 0; last_re = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 0);       chk("rst_done", 32'(DONE), 0);
    chk("rst_pass", 32'(PASS), 0);       chk("rst_code", TOHOST_CODE, 0);
    chk("rst_cnt", 32'(WORD_CNT), 0);    chk("rst_vld", 32'(SIG_VALID), 0);
    chk("rst_re", 32'(RAM_RE), 0);
    @(posedge CLK); #1; RES = 1'b0; ENABLE = 1'b1;

    // Ramp pattern, always-ready sink, zero wait states.
    fill_mem(1'b1);
    clear_mon(1'b1);
    ahb_xfer(TOHOST, 32'd1, 3'b010, 1'b1, 0);
    @(negedge CLK); chk("a_start_re", 32'(RAM_RE), 1);
    wait_done("a_done", 400);
    chk("a_pass", 32'(PASS), 1);         chk("a_code", TOHOST_CODE, 1);
    chk("a_cnt", 32'(WORD_CNT), NW);     chk("a_words", 32'(mon_idx), NW);
    chk("a_last_word", last_word, 32'h3F3F_3F3F);
    ahb_xfer(TOHOST, 32'd7, 3'b010, 1'b1, 0);
    repeat (3) @(negedge CLK);
    chk("a_sticky_done", 32'(DONE), 1);  chk("a_sticky_code", TOHOST_CODE, 1);
    chk("a_no_rerun", 32'(re_cnt), NW);
    disarm();
    @(negedge CLK);
    chk("a_clr_done", 32'(DONE), 0);     chk("a_clr_pass", 32'(PASS), 0);
    chk("a_clr_code", TOHOST_CODE, 0);   chk("a_clr_cnt", 32'(WORD_CNT), 0);

    // Three data-phase wait states, random data, random back-pressure.
    fill_mem(1'b0); rdy_mode = 1;
    clear_mon(1'b0);
    ahb_xfer(TOHOST, 32'd1, 3'b010, 1'b1, 3);
    @(negedge CLK); chk("b_start_re", 32'(RAM_RE), 1);
    wait_done("b_done", 3000);
    chk("b_cnt", 32'(WORD_CNT), NW);     chk("b_words", 32'(mon_idx), NW);
    disarm();

    // Fail code: no dump.
    rdy_mode = 0;
    clear_mon(1'b0);
    ahb_xfer(TOHOST, 32'd5, 3'b010, 1'b1, 0);
    @(negedge CLK);
    chk("c_done", 32'(DONE), 1);         chk("c_pass", 32'(PASS), 0);
    chk("c_code", TOHOST_CODE, 5);       chk("c_cnt", 32'(WORD_CNT), 0);
    repeat (4) @(negedge CLK);
    chk("c_no_re", 32'(re_cnt), 0);      chk("c_no_vld", 32'(vld_cyc), 0);
    disarm();

    // Non-matching transfers and a match while disarmed.
    ahb_xfer(TOHOST, 32'd1, 3'b000, 1'b1, 0);
    repeat (2) @(negedge CLK); chk("d_byte", 32'({BUSY, DONE}), 0);
    ahb_xfer(TOHOST + 4, 32'd1, 3'b010, 1'b1, 0);
    repeat (2) @(negedge CLK); chk("d_addr4", 32'({BUSY, DONE}), 0);
    ahb_xfer(TOHOST, 32'd1, 3'b010, 1'b0, 0);
    repeat (2) @(negedge CLK); chk("d_read", 32'({BUSY, DONE}), 0);
    @(posedge CLK); #1; ENABLE = 1'b0;
    ahb_xfer(TOHOST, 32'd1, 3'b010, 1'b1, 1);
    @(posedge CLK); #1; ENABLE = 1'b1;
    repeat (3) @(negedge CLK);
    chk("d_disarmed", 32'({BUSY, DONE}), 0); chk("d_code", TOHOST_CODE, 0);

    // Sink stalls word 2 for ten cycles.
    fill_mem(1'b0); rdy_mode = 2; stall = 0;
    clear_mon(1'b0);
    ahb_xfer(TOHOST, 32'd1, 3'b010, 1'b1, 0);
    wait_done("e_done", 1000);
    chk("e_stall", 32'(stall), 10);      chk("e_re", 32'(re_cnt), NW);
    chk("e_cnt", 32'(WORD_CNT), NW);
    disarm();

    // Abort during word 5, then re-arm and restart.
    fill_mem(1'b0); rdy_mode = 0;
    clear_mon(1'b0);
    ahb_xfer(TOHOST, 32'd1, 3'b010, 1'b1, 0);
    for (int n = 0; n < 200 && mon_idx < 5; n++) begin
      @(posedge CLK); #1;
    end
    chk("f_reach_w5", 32'(mon_idx), 5);
    ENABLE = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("f_vld", 32'(SIG_VALID), 0);     chk("f_busy", 32'(BUSY), 0);
    chk("f_cnt", 32'(WORD_CNT), 0);      chk("f_re", 32'(RAM_RE), 0);
    @(posedge CLK); #1; ENABLE = 1'b1;
    fill_mem(1'b0);
    clear_mon(1'b0);
    ahb_xfer(TOHOST, 32'd1, 3'b010, 1'b1, 0);
    wait_done("f_redo", 400);
    chk("f_redo_cnt", 32'(WORD_CNT), NW); chk("f_redo_words", 32'(mon_idx), NW);
    disarm();

    // Reset in the middle of a dump.
    clear_mon(1'b0);
    ahb_xfer(TOHOST, 32'd1, 3'b010, 1'b1, 0);
    repeat (20) @(posedge CLK);
    #1; RES = 1'b1;
    @(posedge CLK); #1; RES = 1'b0;
    @(negedge CLK);
    chk("g_busy", 32'(BUSY), 0);         chk("g_vld", 32'(SIG_VALID), 0);
    chk("g_cnt", 32'(WORD_CNT), 0);      chk("g_pass", 32'(PASS), 0);
    chk("g_code", TOHOST_CODE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tohost_sig_dump_ctrl.md
Name: tohost_sig_dump_ctrl

Overview:
Synthesizable controller for the riscv-arch-test flow. It snoops the CPU data AHB-Lite master port for a completed word write to the TOHOST address. On the pass code it sequences word reads of the signature region out of internal RAM through a single read port and streams them over a valid/ready interface, for use by a UART/JTAG dumper or an FPGA self-check. It replaces the testbench-only dump with hardware that runs on silicon.

Parameters:
TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word; the write is matched on all 32 bits.
DUMP_BGN, 32'h0000_2000, first signature byte address; 4-byte aligned, bits [1:0] ignored.
DUMP_END, 32'h0000_2100, exclusive end byte address; 4-byte aligned.
RAM_AW, 22, RAM word-address width; RAM_ADDR = byte_addr[RAM_AW+1:2].

Ports:
CLK  in  1  system clock.
RES  in  1  synchronous active-high reset.
ENABLE  in  1  arms the detector; deassertion aborts a dump.
M_HSEL  in  1  snooped AHB select.
M_HTRANS  in  2  snooped transfer type.
M_HWRITE  in  1  snooped write flag.
M_HSIZE  in  3  snooped size.
M_HADDR  in  32  snooped address.
M_HWDATA  in  32  snooped write data.
M_HREADY  in  1  bus HREADY.
M_HREADYOUT  in  1  slave HREADYOUT.
RAM_RE  out  1  RAM read strobe.
RAM_ADDR  out  RAM_AW  RAM word address.
RAM_RDATA  in  32  RAM read data, valid exactly 1 cycle after RAM_RE.
SIG_VALID  out  1  stream word valid.
SIG_DATA  out  32  signature word.
SIG_LAST  out  1  final word of the region.
SIG_READY  in  1  sink accept.
BUSY  out  1  dump in progress.
DONE  out  1  dump complete; sticky.
PASS  out  1  captured code == 1.
TOHOST_CODE  out  32  captured tohost write data.
WORD_CNT  out  16  words accepted by the sink.

Behaviour:
- Reset values: all outputs 0. FSM = IDLE. match_q = 0.
- Address phase: when M_HREADY & M_HREADYOUT, register match_q = M_HSEL & M_HTRANS[1] & M_HWRITE & (M_HSIZE==3'b010) & (M_HADDR==TOHOST_ADDR). Otherwise hold match_q; wait states in the data phase keep the match alive.
- Data phase: detect = match_q & M_HREADY & M_HREADYOUT.
- IDLE:
  - ENABLE & detect -> latch TOHOST_CODE = M_HWDATA and PASS = (M_HWDATA==1).
  - If PASS and DUMP_END > DUMP_BGN: set addr = DUMP_BGN, go to RD.
  - Otherwise go to DONE with WORD_CNT = 0.
  - Detect while ENABLE = 0 is ignored.
- RD: RAM_RE = 1 for one cycle, RAM_ADDR = addr word index. Next state CAP. BUSY = 1 in RD, CAP, OUT.
- CAP: register SIG_DATA = RAM_RDATA and SIG_LAST = (addr+4 >= DUMP_END). Next state OUT.
- OUT: SIG_VALID = 1.
  - SIG_DATA and SIG_LAST are held stable until SIG_READY.
  - On SIG_VALID & SIG_READY: WORD_CNT += 1. If SIG_LAST go to DONE, else addr += 4 and go to RD.
  - Minimum 3 cycles per word.
- DONE: DONE = 1, BUSY = 0. Holds until RES or ENABLE = 0, then returns to IDLE and clears DONE, PASS, TOHOST_CODE, WORD_CNT.
- Further tohost writes while BUSY or DONE are ignored; the captured code is not overwritten.
- ENABLE = 0 in RD, CAP or OUT: next cycle go to IDLE.
  - SIG_VALID, RAM_RE and BUSY drop. Abort is the only case where SIG_VALID drops without a handshake.
  - WORD_CNT clears.
- RES mid-dump: all state returns to reset values on the next CLK edge.
- Address arithmetic is 32-bit with no wrap handling; DUMP_END must be <= 2^(RAM_AW+2).
- WORD_CNT saturates at 16'hFFFF.

Test Plan:
- Write 32'h1 to TOHOST_ADDR with 0 wait states, RAM[0x2000>>2..] = i*0x01010101, SIG_READY = 1 -> 64 words streamed, SIG_LAST only on word 63 (0x3F3F3F3F), DONE = 1, PASS = 1, WORD_CNT = 64, RAM_RE pulses at cycles 0, 3, 6, ...
- Tohost write with M_HREADYOUT low for 3 data-phase cycles -> detect only on the final ready cycle, and the dump starts one cycle later.
- Write 32'h5 to TOHOST_ADDR -> DONE = 1, PASS = 0, TOHOST_CODE = 5, no RAM_RE, no SIG_VALID.
- Byte write (HSIZE = 0), a write to TOHOST_ADDR+4, and a read of TOHOST_ADDR -> no detect, FSM stays IDLE.
- SIG_READY low for 10 cycles on word 2 -> SIG_VALID and SIG_DATA stable throughout, no extra RAM_RE, final WORD_CNT = 64.
- ENABLE dropped during word 5 -> the next cycle shows SIG_VALID = 0, BUSY = 0, WORD_CNT = 0. After re-arming, a new tohost write restarts the dump from DUMP_BGN.
